// File: rtl/fb_id_ctrl.sv
// fb_id_ctrl: decode-stage sequencer for the Firebird pipeline.
//
// Holds one fetched instruction in a single-entry buffer. It registers the
// decoded fields: encoding format, register indices, write-enable and the
// illegal flag. It issues the instruction to EX with a valid/ready handshake.
// When an instruction reads the destination of a load that has just issued,
// it inserts one bubble. A flush drops whatever ID holds.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   if_valid/if_inst/if_pc instruction offered by IF
//   id_ready               ID accepts the IF instruction this cycle
//                          (combinational from ex_ready)
//   flush                  redirect; kill ID contents, drop the IF instruction
//   ex_ready               EX accepts the ID instruction this cycle
//   id_valid               ID presents an instruction to EX
//   id_inst/id_pc          buffered instruction and PC
//   id_fmt                 0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
//   id_rs1/id_rs2/id_rd    register fields inst[19:15], inst[24:20], inst[11:7]
//   id_reg_we              instruction writes a non-zero rd
//   id_illegal             opcode not recognised
//   stall_cnt              saturating count of load-use bubble cycles
module fb_id_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_inst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             id_ready,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             id_valid,
  output logic [XLEN-1:0]  id_inst,
  output logic [XLEN-1:0]  id_pc,
  output logic [2:0]       id_fmt,
  output logic [4:0]       id_rs1,
  output logic [4:0]       id_rs2,
  output logic [4:0]       id_rd,
  output logic             id_reg_we,
  output logic             id_illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_REG    = 5'b01100;

  // Major opcode (inst[6:2]) to encoding format; inst[1:0] is ignored.
  function automatic logic [2:0] decode_fmt(input logic [4:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: decode_fmt = FMT_I;
      OP_STORE:                 decode_fmt = FMT_S;
      OP_BRANCH:                decode_fmt = FMT_B;
      OP_JAL:                   decode_fmt = FMT_J;
      OP_LUI, OP_AUIPC:         decode_fmt = FMT_U;
      OP_REG:                   decode_fmt = FMT_R;
      default:                  decode_fmt = FMT_ILL;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e            state_q, state_d;
  logic              ld_pend_q, ld_pend_d;
  logic [4:0]        ld_rd_q, ld_rd_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [2:0]        fmt_q, fmt_d;
  logic [4:0]        rs1_q, rs1_d;
  logic [4:0]        rs2_q, rs2_d;
  logic [4:0]        rd_q, rd_d;
  logic              reg_we_q, reg_we_d;
  logic              illegal_q, illegal_d;
  logic              is_load_q, is_load_d;
  logic              rs1_use_q, rs1_use_d;
  logic              rs2_use_q, rs2_use_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  // Decode of the instruction offered by IF.
  logic [2:0] new_fmt;
  logic [4:0] new_rs1, new_rs2, new_rd;
  logic       new_rs1_use, new_rs2_use, new_we, new_load;

  always_comb begin
    new_fmt     = decode_fmt(if_inst[6:2]);
    new_rs1     = if_inst[19:15];
    new_rs2     = if_inst[24:20];
    new_rd      = if_inst[11:7];
    new_rs1_use = (new_fmt == FMT_R) || (new_fmt == FMT_I) ||
                  (new_fmt == FMT_S) || (new_fmt == FMT_B);
    new_rs2_use = (new_fmt == FMT_R) || (new_fmt == FMT_S) || (new_fmt == FMT_B);
    new_we      = ((new_fmt == FMT_R) || (new_fmt == FMT_I) ||
                   (new_fmt == FMT_U) || (new_fmt == FMT_J)) && (new_rd != 5'd0);
    new_load    = (if_inst[6:2] == OP_LOAD);
  end

  // Hazard of the buffered instruction against the outstanding load.
  logic hazard, issue, capture, cap_hazard;

  always_comb begin
    hazard  = ld_pend_q &&
              ((rs1_use_q && (rs1_q == ld_rd_q)) || (rs2_use_q && (rs2_q == ld_rd_q)));
    issue   = (state_q == ST_FULL) && !hazard && ex_ready && !flush;
    capture = !flush && if_valid && ((state_q == ST_EMPTY) || issue);

    id_valid = (state_q == ST_FULL) && !hazard;
    id_ready = (state_q == ST_EMPTY) || ((state_q == ST_FULL) && !hazard && ex_ready);
  end

  // Load tracking: a load issuing with rd != 0 arms the pending flag; any
  // other cycle with ex_ready set means the load has moved past EX.
  always_comb begin
    ld_pend_d = ld_pend_q;
    ld_rd_d   = ld_rd_q;
    if (flush) begin
      ld_pend_d = 1'b0;
    end else if (issue && is_load_q && (rd_q != 5'd0)) begin
      ld_pend_d = 1'b1;
      ld_rd_d   = rd_q;
    end else if (ex_ready) begin
      ld_pend_d = 1'b0;
    end
  end

  // The captured instruction is checked against the load that is issuing in
  // the same cycle, so a dependent instruction goes straight to STALL. This
  // keeps the penalty at exactly one bubble.
  always_comb begin
    cap_hazard = ld_pend_d &&
                 ((new_rs1_use && (new_rs1 == ld_rd_d)) ||
                  (new_rs2_use && (new_rs2 == ld_rd_d)));
  end

  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    pc_d        = pc_q;
    fmt_d       = fmt_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    reg_we_d    = reg_we_q;
    illegal_d   = illegal_q;
    is_load_d   = is_load_q;
    rs1_use_d   = rs1_use_q;
    rs2_use_d   = rs2_use_q;
    stall_cnt_d = stall_cnt_q;

    // Bubble counting is independent of flush; the cycle was lost either way.
    if (state_q == ST_STALL) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (capture) state_d = cap_hazard ? ST_STALL : ST_FULL;
        end
        ST_FULL: begin
          if (hazard) begin
            state_d = ST_STALL;
          end else if (ex_ready) begin
            if (capture) state_d = cap_hazard ? ST_STALL : ST_FULL;
            else         state_d = ST_EMPTY;
          end
        end
        ST_STALL: begin
          if (ex_ready) state_d = ST_FULL;
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    // Decoded fields only change on capture; stale after a flush.
    if (capture) begin
      inst_d    = if_inst;
      pc_d      = if_pc;
      fmt_d     = new_fmt;
      rs1_d     = new_rs1;
      rs2_d     = new_rs2;
      rd_d      = new_rd;
      reg_we_d  = new_we;
      illegal_d = (new_fmt == FMT_ILL);
      is_load_d = new_load;
      rs1_use_d = new_rs1_use;
      rs2_use_d = new_rs2_use;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      ld_pend_q   <= 1'b0;
      ld_rd_q     <= '0;
      inst_q      <= '0;
      pc_q        <= '0;
      fmt_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      reg_we_q    <= 1'b0;
      illegal_q   <= 1'b0;
      is_load_q   <= 1'b0;
      rs1_use_q   <= 1'b0;
      rs2_use_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ld_pend_q   <= ld_pend_d;
      ld_rd_q     <= ld_rd_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
      fmt_q       <= fmt_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      reg_we_q    <= reg_we_d;
      illegal_q   <= illegal_d;
      is_load_q   <= is_load_d;
      rs1_use_q   <= rs1_use_d;
      rs2_use_q   <= rs2_use_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign id_inst    = inst_q;
  assign id_pc      = pc_q;
  assign id_fmt     = fmt_q;
  assign id_rs1     = rs1_q;
  assign id_rs2     = rs2_q;
  assign id_rd      = rd_q;
  assign id_reg_we  = reg_we_q;
  assign id_illegal = illegal_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_fb_id_ctrl.sv
// Testbench for fb_id_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the ID slot.
module tb_fb_id_ctrl;
  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             if_valid = 1'b0;
  logic [XLEN-1:0]  if_inst = '0;
  logic [XLEN-1:0]  if_pc = '0;
  logic             flush = 1'b0;
  logic             ex_ready = 1'b0;
  logic             id_ready;
  logic             id_valid;
  logic [XLEN-1:0]  id_inst;
  logic [XLEN-1:0]  id_pc;
  logic [2:0]       id_fmt;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             id_reg_we;
  logic             id_illegal;
  logic [CNT_W-1:0] stall_cnt;

  fb_id_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
    .id_fmt(id_fmt), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_reg_we(id_reg_we), .id_illegal(id_illegal), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model of the ID slot: occupied / waiting out a bubble, plus the load
  // that was most recently handed to EX.
  logic        m_full, m_stall, m_seen, m_ldp;
  logic [4:0]  m_ldrd;
  logic [31:0] m_inst, m_pc;
  logic [15:0] m_cnt;

  localparam logic [31:0] ADDI   = 32'h00500093;
  localparam logic [31:0] LW     = 32'h00012283;
  localparam logic [31:0] ADD    = 32'h00128333;
  localparam logic [31:0] LUI    = 32'h123452B7;
  localparam logic [31:0] LW_X0  = 32'h00012003;
  localparam logic [31:0] ADD_X0 = 32'h00100333;
  localparam logic [31:0] ILL    = 32'h0000007F;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_fmt(input logic [31:0] i);
    case (i[6:2])
      5'b00000, 5'b00100, 5'b11001: return 3'd1;
      5'b01000:                     return 3'd2;
      5'b11000:                     return 3'd3;
      5'b11011:                     return 3'd5;
      5'b01101, 5'b00101:           return 3'd4;
      5'b01100:                     return 3'd0;
      default:                      return 3'd7;
    endcase
  endfunction

  // Does instruction i read register r (R/I/S/B read rs1; R/S/B read rs2)?
  function automatic logic ref_reads(input logic [31:0] i, input logic [4:0] r);
    logic [2:0] f;
    f = ref_fmt(i);
    return ((f <= 3'd3) && (i[19:15] == r)) ||
           ((f == 3'd0 || f == 3'd2 || f == 3'd3) && (i[24:20] == r));
  endfunction

  task automatic model_reset();
    m_full = 0; m_stall = 0; m_seen = 0; m_ldp = 0; m_ldrd = 0;
    m_inst = 0; m_pc = 0; m_cnt = 0;
  endtask

  task automatic check_all();
    logic [2:0] f;
    logic       we;
    f  = ref_fmt(m_inst);
    we = (f == 3'd0 || f == 3'd1 || f == 3'd4 || f == 3'd5) && (m_inst[11:7] != 5'd0);
    chk("id_valid", 32'(id_valid), 32'(m_full && !m_stall));
    chk("id_ready", 32'(id_ready), 32'(!m_full || (!m_stall && ex_ready)));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    chk("id_inst", id_inst, m_inst);
    chk("id_pc", id_pc, m_pc);
    chk("id_fmt", 32'(id_fmt), m_seen ? 32'(f) : 32'd0);
    chk("id_rs1", 32'(id_rs1), 32'(m_inst[19:15]));
    chk("id_rs2", 32'(id_rs2), 32'(m_inst[24:20]));
    chk("id_rd", 32'(id_rd), 32'(m_inst[11:7]));
    chk("id_reg_we", 32'(id_reg_we), m_seen ? 32'(we) : 32'd0);
    chk("id_illegal", 32'(id_illegal), m_seen ? 32'(f == 3'd7) : 32'd0);
  endtask

  task automatic model_update();
    logic       issue, take, ldp_n;
    logic [4:0] ldrd_n;
    if (m_stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    issue = m_full && !m_stall && ex_ready && !flush;
    if (flush) begin
      m_full = 0; m_stall = 0; m_ldp = 0;
    end else begin
      ldp_n  = m_ldp;
      ldrd_n = m_ldrd;
      if (issue && m_inst[6:2] == 5'b00000 && m_inst[11:7] != 5'd0) begin
        ldp_n = 1; ldrd_n = m_inst[11:7];
      end else if (ex_ready) begin
        ldp_n = 0;
      end
      take = if_valid && (!m_full || issue);
      if (take) begin
        m_inst = if_inst; m_pc = if_pc; m_seen = 1; m_full = 1;
        m_stall = ldp_n && ref_reads(if_inst, ldrd_n);
      end else if (issue) begin
        m_full = 0;
      end else if (m_stall && ex_ready) begin
        m_stall = 0;
      end
      m_ldp = ldp_n; m_ldrd = ldrd_n;
    end
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic step();
    #1;
    check_all();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    if_valid = 1; if_inst = inst; if_pc = pc;
    step();
    if_valid = 0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0] op;
    case ($urandom_range(0, 9))
      0: op = 5'b00000;  1: op = 5'b00100;  2: op = 5'b11001;
      3: op = 5'b01000;  4: op = 5'b11000;  5: op = 5'b11011;
      6: op = 5'b01101;  7: op = 5'b00101;  8: op = 5'b01100;
      default: op = 5'($urandom);
    endcase
    return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom_range(0, 3)), op, 2'($urandom)};
  endfunction

  initial begin
    model_reset();
    // Reset state
    @(negedge clk); @(negedge clk);
    check_all();
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_ready", 32'(id_ready), 32'd1);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_fmt", 32'(id_fmt), 32'd0);
    rst_n = 1; ex_ready = 1;

    // addi x1,x0,5 presented the next cycle
    send(ADDI, 32'h100);
    chk("addi_valid", 32'(id_valid), 32'd1);
    chk("addi_fmt", 32'(id_fmt), 32'd1);
    chk("addi_rd", 32'(id_rd), 32'd1);
    chk("addi_rs1", 32'(id_rs1), 32'd0);
    chk("addi_we", 32'(id_reg_we), 32'd1);
    chk("addi_pc", id_pc, 32'h100);
    step();

    // lw x5 then dependent add: one bubble
    send(LW, 32'h200);
    send(ADD, 32'h204);
    chk("lu_bubble_valid", 32'(id_valid), 32'd0);
    chk("lu_bubble_ready", 32'(id_ready), 32'd0);
    step();
    chk("lu_issue_valid", 32'(id_valid), 32'd1);
    chk("lu_issue_inst", id_inst, ADD);
    chk("lu_cnt", 32'(stall_cnt), 32'd1);
    step();

    // lw x5 then lui x5: no dependency
    send(LW, 32'h210);
    send(LUI, 32'h214);
    chk("lui_valid", 32'(id_valid), 32'd1);
    chk("lui_fmt", 32'(id_fmt), 32'd4);
    step();
    // lw x0 then add reading x0: no tracking of x0
    send(LW_X0, 32'h220);
    send(ADD_X0, 32'h224);
    chk("x0_valid", 32'(id_valid), 32'd1);
    step();
    chk("nobubble_cnt", 32'(stall_cnt), 32'd1);

    // Backpressure for three cycles
    send(ADDI, 32'h300);
    ex_ready = 0;
    repeat (3) begin
      #1;
      chk("bp_inst", id_inst, ADDI);
      chk("bp_pc", id_pc, 32'h300);
      chk("bp_ready", 32'(id_ready), 32'd0);
      chk("bp_valid", 32'(id_valid), 32'd1);
      step();
    end
    ex_ready = 1;
    step();
    chk("bp_once", 32'(id_valid), 32'd0);

    // Flush with a pending load and an incoming instruction
    send(LW, 32'h400);
    send(ADDI, 32'h404);
    flush = 1; ex_ready = 0; if_valid = 1; if_inst = ADD; if_pc = 32'h408;
    step();
    flush = 0; if_valid = 0;
    #1;
    chk("fl_valid", 32'(id_valid), 32'd0);
    chk("fl_ready", 32'(id_ready), 32'd1);
    send(ADD, 32'h40C);
    chk("fl_ldclr_valid", 32'(id_valid), 32'd1);
    ex_ready = 1;
    step();

    // Illegal opcode
    send(ILL, 32'h500);
    chk("ill_fmt", 32'(id_fmt), 32'd7);
    chk("ill_flag", 32'(id_illegal), 32'd1);
    chk("ill_valid", 32'(id_valid), 32'd1);
    chk("ill_we", 32'(id_reg_we), 32'd0);
    step();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if_valid = ($urandom_range(0, 9) < 7);
      if_inst  = rand_inst();
      if_pc    = $urandom;
      ex_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 19) == 0);
      step();
    end

    // Asynchronous reset mid-operation
    flush = 0; ex_ready = 0;
    send(ADDI, 32'h600);
    rst_n = 0;
    #2;
    model_reset();
    check_all();
    chk("arst_valid", 32'(id_valid), 32'd0);
    chk("arst_cnt", 32'(stall_cnt), 32'd0);
    @(posedge clk); @(negedge clk);
    rst_n = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
